tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler.sv | 177 +++++++++++++++++
 tb/tb_tick_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// ---------------------------------------------------------------------------
// tick_scheduler
//
// Game-timing block. Produces a free-running divide-by-4 pixel enable and a
// programmable game-tick enable controlled by a small IDLE/RUN/PAUSE FSM.
// The tick divide ratio can be reconfigured at any time through a
// valid/ready handshake; while running, a new ratio is parked in a pending
// register and only takes effect at the next tick boundary, so the period
// in flight is never cut short.
//
// Parameters
//   DIV_W        width of the tick divide ratio
//   CNT_W        width of the tick counter output
//   DEFAULT_DIV  divide ratio loaded at reset
//
// Ports
//   clk          single clock, rising-edge active
//   rst          synchronous active-high reset
//   start        one-cycle pulse, IDLE -> RUN
//   pause        level: 1 requests PAUSE, 0 requests RUN
//   stop         one-cycle pulse, any state -> IDLE
//   cfg_valid    cfg_div holds a new divide ratio
//   cfg_div      requested divide ratio (0 and 1 are clamped to 2)
//   cfg_ready    a configuration can be accepted this cycle
//   pix_en       one-cycle pulse every 4 clocks, independent of the FSM
//   tick_en      one-cycle game-tick enable (registered)
//   tick_count   ticks issued since the last start, wraps modulo 2^CNT_W
//   state        FSM state: IDLE=0, RUN=1, PAUSE=2
// ---------------------------------------------------------------------------
module tick_scheduler #(
    parameter int DIV_W       = 24,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             pix_en,
    output logic             tick_en,
    output logic [CNT_W-1:0] tick_count,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       pix_cnt;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] tick_cnt;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] pend_div;
    logic             pend_vld;
    logic             cfg_take;
    logic             tick_hit;

    // A ratio below 2 would leave no idle cycle between ticks; force the
    // smallest meaningful period instead.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        if (d < DIV_TWO) begin
            return DIV_TWO;
        end
        return d;
    endfunction

    assign pix_en    = (pix_cnt == 2'd3);
    assign cfg_ready = ~pend_vld;
    assign cfg_take  = cfg_valid & ~pend_vld;

    // div_reg never drops below 2, so div_reg-1 cannot underflow. The >=
    // compare (rather than ==) makes a ratio lowered during PAUSE below the
    // held count fire immediately on resume instead of wrapping the counter.
    assign div_m1   = div_reg - DIV_ONE;
    assign tick_hit = (state == ST_RUN) && (tick_cnt >= div_m1);

    // Next-state: stop beats everything, start only matters in IDLE, pause
    // only matters once running.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nxt = ST_RUN;
                ST_RUN:   if (pause) state_nxt = ST_PAUSE;
                ST_PAUSE: if (!pause) state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pending ratio is pure data: it is only observed while pend_vld is set,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (cfg_take && (state == ST_RUN) && !stop) begin
            pend_div <= clamp_div(cfg_div);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pix_cnt    <= 2'd0;
            tick_cnt   <= '0;
            tick_en    <= 1'b0;
            tick_count <= '0;
            div_reg    <= DIV_RST;
            pend_vld   <= 1'b0;
        end else begin
            pix_cnt <= pix_cnt + 2'd1;
            state   <= state_nxt;
            tick_en <= 1'b0;

            if (stop) begin
                // Returning to IDLE: flush a parked ratio, or take a fresh
                // one directly since no period is in flight anymore.
                tick_cnt <= '0;
                if (pend_vld) begin
                    div_reg  <= pend_div;
                    pend_vld <= 1'b0;
                end else if (cfg_take) begin
                    div_reg <= clamp_div(cfg_div);
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        tick_cnt <= '0;
                        if (start) begin
                            tick_count <= '0;
                        end
                        if (cfg_take) begin
                            div_reg <= clamp_div(cfg_div);
                        end
                    end
                    ST_RUN: begin
                        if (tick_hit) begin
                            tick_cnt   <= '0;
                            tick_en    <= 1'b1;
                            tick_count <= tick_count + CNT_ONE;
                            // Period boundary: the parked ratio governs the
                            // period that starts now.
                            if (pend_vld) begin
                                div_reg  <= pend_div;
                                pend_vld <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + DIV_ONE;
                        end
                        if (cfg_take) begin
                            pend_vld <= 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (cfg_take) begin
                            div_reg <= clamp_div(cfg_div);
                        end
                    end
                    default: begin
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tick_scheduler
//
// Directed bench for tick_scheduler. Expected tick_en times (absolute clock
// edge numbers) are queued when a run is launched; a negedge monitor pops
// one entry per observed tick and compares the edge number. A second
// instance with a 4-bit tick counter shares every input to exercise wrap.
// ---------------------------------------------------------------------------
module tb_tick_scheduler;

    localparam int DIV_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             pause;
    logic             stop;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             pix_en;
    logic             tick_en;
    logic [15:0]      tick_count;
    logic [1:0]       state;

    logic             cfg_ready2;
    logic             pix_en2;
    logic             tick_en2;
    logic [3:0]       tick_count2;
    logic [1:0]       state2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];
    int c;

    tick_scheduler #(.DIV_W(DIV_W), .CNT_W(16), .DEFAULT_DIV(1000000)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
        .pix_en(pix_en), .tick_en(tick_en), .tick_count(tick_count),
        .state(state)
    );

    tick_scheduler #(.DIV_W(DIV_W), .CNT_W(4), .DEFAULT_DIV(1000000)) dut4 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready2),
        .pix_en(pix_en2), .tick_en(tick_en2), .tick_count(tick_count2),
        .state(state2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Each observed tick must match the oldest queued edge number; an
    // unexpected tick compares against -1 and therefore fails.
    always @(negedge clk) begin
        int want;
        if (tick_en === 1'b1) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("tick_time", cyc, want);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(1); stop = 1'b0;
    endtask

    task automatic load_cfg(input int d);
        cfg_valid = 1'b1; cfg_div = DIV_W'(d); step(1); cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        cfg_valid = 1'b0; cfg_div = '0;
        @(negedge clk);
        step(2);

        // Reset state
        chk("rst_state", state, 0);
        chk("rst_tick_en", tick_en, 0);
        chk("rst_tick_count", tick_count, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_pix_en", pix_en, 0);
        rst = 1'b0;

        // Pixel enable: one pulse every 4th cycle after release
        for (int k = 0; k < 12; k++) begin
            chk("pix_en", pix_en, (k % 4 == 3) ? 1 : 0);
            step(1);
        end
        chk("idle_state", state, 0);

        // div=4 loaded in IDLE, then run 12 cycles
        load_cfg(4);
        chk("idle_cfg_ready", cfg_ready, 1);
        c = cyc;
        exp_q.push_back(c + 5); exp_q.push_back(c + 9); exp_q.push_back(c + 13);
        pulse_start();
        chk("run_state", state, 1);
        to_cyc(c + 13);
        chk("div4_count", tick_count, 3);
        step(1);
        chk("div4_q_empty", exp_q.size(), 0);
        pulse_stop();
        chk("stop_state", state, 0);
        chk("idle_hold_count", tick_count, 3);

        // div=5, pause for 7 cycles at tick_cnt=2
        load_cfg(5);
        c = cyc;
        exp_q.push_back(c + 13); exp_q.push_back(c + 18);
        pulse_start();
        to_cyc(c + 3);
        pause = 1'b1;
        step(1);
        chk("pause_state", state, 2);
        to_cyc(c + 10);
        chk("pause_hold_count", tick_count, 0);
        pause = 1'b0;
        step(1);
        chk("resume_state", state, 1);
        to_cyc(c + 18);
        step(1);
        chk("pause_q_empty", exp_q.size(), 0);
        chk("pause_count", tick_count, 2);
        pulse_stop();

        // div=6 running, cfg 3 parked until the period boundary
        load_cfg(6);
        c = cyc;
        exp_q.push_back(c + 7);  exp_q.push_back(c + 10);
        exp_q.push_back(c + 13); exp_q.push_back(c + 16);
        pulse_start();
        to_cyc(c + 3);
        cfg_valid = 1'b1; cfg_div = DIV_W'(3);
        step(1);
        cfg_valid = 1'b0;
        chk("pend_ready_low", cfg_ready, 0);
        to_cyc(c + 6);
        chk("pend_ready_still_low", cfg_ready, 0);
        to_cyc(c + 7);
        chk("pend_ready_back", cfg_ready, 1);
        to_cyc(c + 16);
        step(1);
        chk("pend_q_empty", exp_q.size(), 0);
        chk("pend_count", tick_count, 4);
        pulse_stop();

        // div lowered in PAUSE below tick_cnt+1 -> tick on first RUN cycle
        load_cfg(6);
        c = cyc;
        exp_q.push_back(c + 8); exp_q.push_back(c + 11);
        pulse_start();
        to_cyc(c + 4);
        pause = 1'b1;
        step(1);
        cfg_valid = 1'b1; cfg_div = DIV_W'(3);
        step(1);
        cfg_valid = 1'b0;
        chk("pause_cfg_ready", cfg_ready, 1);
        pause = 1'b0;
        to_cyc(c + 11);
        step(1);
        chk("lower_q_empty", exp_q.size(), 0);
        chk("lower_count", tick_count, 2);
        pulse_stop();

        // start+stop together in IDLE, then cfg_div=0 clamps to 2
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_state", state, 0);
        load_cfg(0);
        c = cyc;
        exp_q.push_back(c + 3); exp_q.push_back(c + 5); exp_q.push_back(c + 7);
        pulse_start();
        to_cyc(c + 7);
        cfg_valid = 1'b1; cfg_div = DIV_W'(5);
        step(1);
        cfg_valid = 1'b0;
        chk("stop_pend_ready", cfg_ready, 0);
        pulse_stop();
        chk("stop_pend_state", state, 0);
        chk("stop_pend_ready_back", cfg_ready, 1);
        chk("stop_pend_count", tick_count, 3);
        chk("clamp_q_empty", exp_q.size(), 0);

        // pending 5 was loaded by stop
        c = cyc;
        exp_q.push_back(c + 6); exp_q.push_back(c + 11);
        pulse_start();
        chk("restart_clear", tick_count, 0);
        to_cyc(c + 11);
        step(1);
        chk("stopload_q_empty", exp_q.size(), 0);
        chk("stopload_count", tick_count, 2);
        pulse_stop();

        // div=2 for 34 cycles: 4-bit counter wraps 15 -> 0
        load_cfg(2);
        c = cyc;
        for (int k = 1; k <= 17; k++) exp_q.push_back(c + 1 + 2 * k);
        pulse_start();
        to_cyc(c + 31);
        chk("wrap_15", tick_count2, 15);
        to_cyc(c + 33);
        chk("wrap_0", tick_count2, 0);
        to_cyc(c + 35);
        chk("wrap_1", tick_count2, 1);
        chk("wide_count_17", tick_count, 17);

        // reset mid-RUN with a config parked
        cfg_valid = 1'b1; cfg_div = DIV_W'(7);
        step(1);
        cfg_valid = 1'b0;
        chk("mid_pend_ready", cfg_ready, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_tick_en", tick_en, 0);
        chk("mid_rst_count", tick_count, 0);
        chk("mid_rst_count4", tick_count2, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        chk("mid_rst_pix_en", pix_en, 0);
        chk("mid_rst_q_empty", exp_q.size(), 0);

        // Discarded pending: default ratio is huge, so no tick may appear
        pulse_start();
        step(12);
        chk("post_rst_run", state, 1);
        chk("post_rst_no_tick", tick_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
